cp0_trap_controller: RTL and testbench
======================================

# cp0_trap_controller

Sequencing controller for the CP0 exception and interrupt path. It samples hardware interrupt lines and arbitrates per cycle between interrupt, synchronous exception, `eret` and `mtc0` from the M-stage. It owns the SR/Cause/EPC registers and runs a two-state FSM that flushes the pipeline and holds a redirect PC until the front end accepts it. It replaces ad-hoc combinational CP0 submission with a registered, handshaken trap entry/exit.

## Interface
- `HANDLER_PC`, 32'h0000_4180, trap vector
- `PRID`, 32'h0000_0000, constant value returned for PRId (reg 15)
- `clk`  in  1  sole clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `hw_int`  in  6  interrupt lines, level, synchronous to `clk`
- `m_valid`  in  1  M-stage holds a real instruction (not a bubble)
- `m_pc`  in  32  M-stage PC
- `m_bd`  in  1  M-stage instruction is in a delay slot
- `exc_valid`  in  1  M-stage instruction raised an exception
- `exc_code`  in  5  its ExcCode
- `eret_valid`  in  1  M-stage instruction is `eret`
- `mtc0_valid`  in  1  M-stage instruction is `mtc0`
- `mtc0_addr`  in  5  CP0 register number
- `mtc0_data`  in  32  GPR rt value
- `mfc0_addr`  in  5  read address
- `mfc0_data`  out  32  combinational read data
- `pipe_ready`  in  1  front end accepts the redirect this cycle
- `flush`  out  1  kill F/D/E/M
- `stall`  out  1  freeze PC and pipeline registers
- `redirect_valid`  out  1  redirect PC is valid
- `redirect_pc`  out  32  target PC
- `sr`, `cause`, `epc`  out  32 each  architectural register values

## Operation
- Registers: SR holds IM[15:10], EXL[1] and IE[0], with all other bits 0. Cause holds BD[31], IP[15:10] and ExcCode[6:2], with all other bits 0. EPC is 32 bits. Reset value of all three is 0.
- `hw_int` is registered into `ip_q`. Cause.IP takes the value of `ip_q` on every edge, in every state.
- `int_req = |(ip_q & SR.IM) & SR.IE & ~SR.EXL & m_valid`. Interrupts are deferred while `m_valid` = 0.
- Priority in IDLE: `int_req` > `exc_valid` > `eret_valid` > `mtc0_valid`. Only the winner takes effect.
- Trap entry (interrupt or exception):
  - EPC = `m_bd ? m_pc-4 : m_pc`.
  - Cause.BD = `m_bd`.
  - Cause.ExcCode = 0 (Int) for an interrupt, otherwise `exc_code`.
  - SR.EXL = 1.
  - Next state REDIRECT with target `HANDLER_PC`.
- `eret`: SR.EXL = 0 and next state REDIRECT with target = current EPC. This happens even if EXL is already 0.
- `mtc0`:
  - Address 12 writes SR from the masked `mtc0_data`.
  - Address 14 writes EPC.
  - Address 13 (Cause), address 15 and other addresses are ignored.
  - The write is dropped if a trap wins the same cycle.
- `mfc0` reads 12/13/14/15 and returns 0 for other addresses. The read returns register contents, not bypassed in-flight writes.
- FSM states:
  - IDLE: all control outputs are 0.
  - REDIRECT: `flush` = `stall` = `redirect_valid` = 1 and `redirect_pc` = latched target. The state returns to IDLE on the edge where `pipe_ready` = 1. All M-stage inputs are ignored in REDIRECT.

## Timing
- Decision in IDLE during cycle T. Register updates and entry to REDIRECT occur at edge T+1. `redirect_valid` is high from cycle T+1.
- Minimum REDIRECT duration is 1 cycle, when `pipe_ready` is already 1. There is no upper bound.
- An `mtc0` write is visible on `sr`/`epc` and via `mfc0` from cycle T+1.
- `hw_int` to Cause.IP latency: 2 edges. `hw_int` to a possible trap decision: visible in `int_req` 1 edge after the input changes.
- Reset assertion at any time, including mid-REDIRECT, clears all state asynchronously. The FSM returns to IDLE with all outputs 0; the pending redirect is lost.
- Outputs `sr`/`cause`/`epc`/`redirect_pc` are register-driven. `mfc0_data` is combinational from `mfc0_addr`.

## Structure
- Shared package `cp0_pkg`:
  - Register numbers SR=12, CAUSE=13, EPC=14, PRID=15.
  - `EXC_INT`=0.
  - SR/Cause field bit positions and writable-bit masks.
  - FSM state enum {IDLE, REDIRECT}.
- One natural sub-module: `cp0_regfile`, holding SR/Cause/EPC, write ports and `mfc0` read mux. The FSM and arbitration live in the top.

## Test plan
- Reset, then `mtc0` 12 ← 32'hFFFF_FFFF → `sr` = 32'h0000_FC03 next cycle; `mfc0` 12 returns the same.
- SR = 32'h0000_0401, `hw_int`[0] = 1, `m_pc` = 32'h3008, `m_bd` = 1 → after 2 edges trap entry:
  - EPC = 32'h3004, Cause = 32'h8000_0400, SR.EXL = 1.
  - `redirect_pc` = 32'h4180, held for 3 cycles with `pipe_ready` low, released on the 4th.
- `exc_valid` with `exc_code` = 12 together with `eret_valid` and `mtc0` 14 ← 32'h1234 in one cycle → exception wins: Cause.ExcCode = 12, EPC = `m_pc` (not 32'h1234).
- `eret` with EPC = 32'h3010 → SR.EXL = 0, `redirect_pc` = 32'h3010; an interrupt pending during REDIRECT is taken only after the return to IDLE.
- Interrupt pending with `m_valid` = 0 for 5 cycles → no trap; trap fires in the cycle `m_valid` rises.
- `reset_n` low during REDIRECT → `flush`/`redirect_valid` drop immediately; SR/Cause/EPC = 0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, field positions, masks and FSM states.
package cp0_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  localparam logic [4:0] EXC_INT = 5'd0;

  localparam int SR_IE_BIT  = 0;
  localparam int SR_EXL_BIT = 1;
  localparam int SR_IM_LSB  = 10;
  localparam int SR_IM_MSB  = 15;

  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  // Only IM, EXL and IE exist in SR; everything else reads as zero.
  localparam logic [31:0] SR_WMASK = 32'h0000_FC03;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } cp0_state_e;

  // A delay-slot instruction restarts at its branch, one word earlier.
  function automatic logic [31:0] trap_epc(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_trap_controller_if.sv
// M-stage / front-end signal bundle of the CP0 trap controller.
interface cp0_trap_controller_if;
  logic [5:0]  hw_int;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        eret_valid;
  logic        mtc0_valid;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        pipe_ready;
  logic        flush;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] sr;
  logic [31:0] cause;
  logic [31:0] epc;

  // Controller side
  modport slave (
    input  hw_int, m_valid, m_pc, m_bd, exc_valid, exc_code, eret_valid,
           mtc0_valid, mtc0_addr, mtc0_data, mfc0_addr, pipe_ready,
    output mfc0_data, flush, stall, redirect_valid, redirect_pc, sr, cause, epc
  );

  // Pipeline side
  modport master (
    output hw_int, m_valid, m_pc, m_bd, exc_valid, exc_code, eret_valid,
           mtc0_valid, mtc0_addr, mtc0_data, mfc0_addr, pipe_ready,
    input  mfc0_data, flush, stall, redirect_valid, redirect_pc, sr, cause, epc
  );
endinterface

// File: rtl/cp0_regfile.sv
// SR / Cause / EPC storage with trap, eret and mtc0 update ports and mfc0 read mux.
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  ip_i,
  input  logic        trap_i,
  input  logic        trap_bd_i,
  input  logic [4:0]  trap_code_i,
  input  logic [31:0] trap_epc_i,
  input  logic        eret_i,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i,
  input  logic [4:0]  rd_addr_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] sr_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o
);

  logic [31:0] sr_q, sr_d;
  logic [31:0] epc_q, epc_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [5:0]  cip_q;

  // Next-state for SR/EPC/Cause; the ports are mutually exclusive by construction upstream
  always_comb begin
    sr_d   = sr_q;
    epc_d  = epc_q;
    bd_d   = bd_q;
    code_d = code_q;
    if (trap_i) begin
      epc_d              = trap_epc_i;
      bd_d               = trap_bd_i;
      code_d             = trap_code_i;
      sr_d[SR_EXL_BIT]   = 1'b1;
    end else if (eret_i) begin
      sr_d[SR_EXL_BIT]   = 1'b0;
    end else if (wr_en_i) begin
      case (wr_addr_i)
        REG_SR:  sr_d  = wr_data_i & SR_WMASK;
        REG_EPC: epc_d = wr_data_i;
        default: ;
      endcase
    end
  end

  // Register state; Cause.IP follows the sampled interrupt lines every edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q   <= '0;
      epc_q  <= '0;
      bd_q   <= 1'b0;
      code_q <= '0;
      cip_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      epc_q  <= epc_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      cip_q  <= ip_i;
    end
  end

  // Assemble Cause from its fields
  always_comb begin
    cause_o                             = '0;
    cause_o[CAUSE_BD_BIT]               = bd_q;
    cause_o[CAUSE_IP_MSB:CAUSE_IP_LSB]  = cip_q;
    cause_o[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = code_q;
  end

  assign sr_o  = sr_q;
  assign epc_o = epc_q;

  // mfc0 read mux, architectural contents only
  always_comb begin
    case (rd_addr_i)
      REG_SR:    rd_data_o = sr_q;
      REG_CAUSE: rd_data_o = cause_o;
      REG_EPC:   rd_data_o = epc_q;
      REG_PRID:  rd_data_o = PRID;
      default:   rd_data_o = '0;
    endcase
  end

endmodule

// File: rtl/cp0_trap_controller.sv
// CP0 trap sequencing: interrupt sampling, M-stage arbitration and redirect FSM.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   ST_IDLE     | no redirect pending; arbitrate int > exc > eret > mtc0
//   ST_REDIRECT | flush+stall asserted, target held until pipe_ready
module cp0_trap_controller
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h0000_0000
) (
  input logic            clk,
  input logic            reset_n,
  cp0_trap_controller_if.slave bus
);

  cp0_state_e  state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [5:0]  ip_q;

  logic [31:0] sr, cause, epc, rd_data;
  logic        int_req;
  logic        take_trap, take_eret, take_wr;
  logic [4:0]  trap_code;

  // Sample the interrupt lines
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ip_q <= '0;
    else          ip_q <= bus.hw_int;
  end

  // Interrupts wait for a real instruction in M so EPC is meaningful
  assign int_req = (|(ip_q & sr[SR_IM_MSB:SR_IM_LSB])) & sr[SR_IE_BIT]
                   & ~sr[SR_EXL_BIT] & bus.m_valid;

  // Arbitration and next-state; M-stage inputs are ignored outside IDLE
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    take_trap = 1'b0;
    take_eret = 1'b0;
    take_wr   = 1'b0;
    trap_code = EXC_INT;
    case (state_q)
      ST_IDLE: begin
        if (int_req) begin
          take_trap = 1'b1;
        end else if (bus.exc_valid) begin
          take_trap = 1'b1;
          trap_code = bus.exc_code;
        end else if (bus.eret_valid) begin
          take_eret = 1'b1;
        end else if (bus.mtc0_valid) begin
          take_wr = 1'b1;
        end
        if (take_trap) begin
          state_d  = ST_REDIRECT;
          target_d = HANDLER_PC;
        end else if (take_eret) begin
          state_d  = ST_REDIRECT;
          target_d = epc;
        end
      end
      ST_REDIRECT: begin
        if (bus.pipe_ready) begin
          state_d  = ST_IDLE;
          target_d = '0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        target_d = '0;
      end
    endcase
  end

  // FSM state and redirect target; target is cleared in IDLE so redirect_pc reads 0 there
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  cp0_regfile #(.PRID(PRID)) u_regfile (
    .clk         (clk),
    .reset_n     (reset_n),
    .ip_i        (ip_q),
    .trap_i      (take_trap),
    .trap_bd_i   (bus.m_bd),
    .trap_code_i (trap_code),
    .trap_epc_i  (trap_epc(bus.m_pc, bus.m_bd)),
    .eret_i      (take_eret),
    .wr_en_i     (take_wr),
    .wr_addr_i   (bus.mtc0_addr),
    .wr_data_i   (bus.mtc0_data),
    .rd_addr_i   (bus.mfc0_addr),
    .rd_data_o   (rd_data),
    .sr_o        (sr),
    .cause_o     (cause),
    .epc_o       (epc)
  );

  assign bus.flush          = (state_q == ST_REDIRECT);
  assign bus.stall          = (state_q == ST_REDIRECT);
  assign bus.redirect_valid = (state_q == ST_REDIRECT);
  assign bus.redirect_pc    = target_q;
  assign bus.sr             = sr;
  assign bus.cause          = cause;
  assign bus.epc            = epc;
  assign bus.mfc0_data      = rd_data;

endmodule

// File: tb/tb_cp0_trap_controller.sv
// Bench for cp0_trap_controller: directed scenarios plus random traffic against a field-level model.
module tb_cp0_trap_controller;

  localparam logic [31:0] HANDLER = 32'h0000_4180;
  localparam logic [31:0] PRID_V  = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cp0_trap_controller_if bus();

  cp0_trap_controller #(.HANDLER_PC(HANDLER), .PRID(PRID_V)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural fields) ----------------
  bit [5:0]  md_im, md_ipq, md_cip;
  bit        md_exl, md_ie, md_bd, md_busy;
  bit [4:0]  md_code;
  bit [31:0] md_epc, md_tgt;

  function automatic logic [31:0] m_sr();
    return {16'h0, md_im, 8'h0, md_exl, md_ie};
  endfunction
  function automatic logic [31:0] m_cause();
    return {md_bd, 15'h0, md_cip, 3'h0, md_code, 2'h0};
  endfunction
  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr();
      5'd13:   return m_cause();
      5'd14:   return md_epc;
      5'd15:   return PRID_V;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      md_im <= 0; md_ipq <= 0; md_cip <= 0; md_exl <= 0; md_ie <= 0;
      md_bd <= 0; md_busy <= 0; md_code <= 0; md_epc <= 0; md_tgt <= 0;
    end else begin
      md_ipq <= bus.hw_int;
      md_cip <= md_ipq;
      if (md_busy) begin
        if (bus.pipe_ready) begin
          md_busy <= 0;
          md_tgt  <= 0;
        end
      end else if ((((md_ipq & md_im) != 0) && md_ie && !md_exl && bus.m_valid) || bus.exc_valid) begin
        md_epc  <= bus.m_bd ? bus.m_pc - 32'd4 : bus.m_pc;
        md_bd   <= bus.m_bd;
        md_code <= (((md_ipq & md_im) != 0) && md_ie && !md_exl && bus.m_valid) ? 5'd0 : bus.exc_code;
        md_exl  <= 1;
        md_busy <= 1;
        md_tgt  <= HANDLER;
      end else if (bus.eret_valid) begin
        md_exl  <= 0;
        md_busy <= 1;
        md_tgt  <= md_epc;
      end else if (bus.mtc0_valid) begin
        if (bus.mtc0_addr == 5'd12) begin
          md_im  <= bus.mtc0_data[15:10];
          md_exl <= bus.mtc0_data[1];
          md_ie  <= bus.mtc0_data[0];
        end else if (bus.mtc0_addr == 5'd14) begin
          md_epc <= bus.mtc0_data;
        end
      end
    end
  end

  // Compare process: mid-cycle, every cycle out of reset
  always @(negedge clk) begin
    if (reset_n) begin
      chk("flush",          {31'h0, bus.flush},          {31'h0, md_busy});
      chk("stall",          {31'h0, bus.stall},          {31'h0, md_busy});
      chk("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, md_busy});
      chk("redirect_pc",    bus.redirect_pc,             md_busy ? md_tgt : 32'h0);
      chk("sr",             bus.sr,                      m_sr());
      chk("cause",          bus.cause,                   m_cause());
      chk("epc",            bus.epc,                     md_epc);
      chk("mfc0_data",      bus.mfc0_data,               m_read(bus.mfc0_addr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_inputs();
    bus.m_valid = 0; bus.m_pc = 0; bus.m_bd = 0;
    bus.exc_valid = 0; bus.exc_code = 0; bus.eret_valid = 0;
    bus.mtc0_valid = 0; bus.mtc0_addr = 0; bus.mtc0_data = 0;
    bus.mfc0_addr = 0; bus.pipe_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_valid = 1; bus.mtc0_addr = a; bus.mtc0_data = d;
    step();
    bus.mtc0_valid = 0;
  endtask

  initial begin
    bus.hw_int = 0;
    idle_inputs();
    reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flush", {31'h0, bus.flush}, 32'h0);
    chk("rst_rv",    {31'h0, bus.redirect_valid}, 32'h0);
    chk("rst_sr",    bus.sr, 32'h0);
    chk("rst_cause", bus.cause, 32'h0);
    chk("rst_epc",   bus.epc, 32'h0);
    reset_n = 1;
    step();

    // SR write mask and mfc0 readback
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("sr_mask", bus.sr, 32'h0000_FC03);
    bus.mfc0_addr = 5'd12; #1;
    chk("mfc0_sr", bus.mfc0_data, 32'h0000_FC03);

    // Interrupt in a delay slot
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int = 6'd1; bus.m_valid = 1; bus.m_pc = 32'h3008; bus.m_bd = 1;
    step();
    chk("int_not_yet", {31'h0, bus.redirect_valid}, 32'h0);
    step();
    chk("int_epc",   bus.epc, 32'h3004);
    chk("int_cause", bus.cause, 32'h8000_0400);
    chk("int_sr",    bus.sr, 32'h0000_0403);
    chk("int_rpc",   bus.redirect_pc, 32'h4180);
    bus.m_valid = 0; bus.m_bd = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("int_hold", {31'h0, bus.redirect_valid}, 32'h1);
    end
    bus.pipe_ready = 1;
    step();
    chk("int_release", {31'h0, bus.redirect_valid}, 32'h0);
    bus.pipe_ready = 0; bus.hw_int = 0;
    repeat (3) step();

    // Exception beats eret and mtc0 in the same cycle
    bus.m_valid = 1; bus.m_pc = 32'h2000; bus.exc_valid = 1; bus.exc_code = 5'd12;
    bus.eret_valid = 1; bus.mtc0_valid = 1; bus.mtc0_addr = 5'd14; bus.mtc0_data = 32'h1234;
    step();
    idle_inputs();
    chk("exc_cause", bus.cause, 32'h0000_0030);
    chk("exc_epc",   bus.epc, 32'h2000);
    chk("exc_rpc",   bus.redirect_pc, 32'h4180);
    bus.pipe_ready = 1;
    step();
    bus.pipe_ready = 0;

    // eret to 0x3010, interrupt pending during REDIRECT waits for IDLE
    bus.hw_int = 6'd1;
    mtc0(5'd14, 32'h3010);
    bus.m_valid = 1; bus.m_pc = 32'h3010; bus.eret_valid = 1;
    step();
    bus.eret_valid = 0;
    chk("eret_sr",  bus.sr, 32'h0000_0401);
    chk("eret_rpc", bus.redirect_pc, 32'h3010);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("eret_hold_rpc", bus.redirect_pc, 32'h3010);
    end
    bus.pipe_ready = 1;
    step();
    chk("eret_back_idle", {31'h0, bus.redirect_valid}, 32'h0);
    step();
    chk("post_eret_int_rv",  {31'h0, bus.redirect_valid}, 32'h1);
    chk("post_eret_int_rpc", bus.redirect_pc, 32'h4180);
    chk("post_eret_int_epc", bus.epc, 32'h3010);

    // Interrupt deferred while m_valid is low
    bus.m_valid = 0;
    step();
    bus.eret_valid = 1;
    step();
    bus.eret_valid = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("defer_no_trap", {31'h0, bus.redirect_valid}, 32'h0);
    end
    bus.m_valid = 1; bus.m_pc = 32'h5000;
    step();
    chk("defer_trap_rv",  {31'h0, bus.redirect_valid}, 32'h1);
    chk("defer_trap_epc", bus.epc, 32'h5000);

    // Reset in the middle of REDIRECT
    bus.pipe_ready = 0;
    step();
    reset_n = 0;
    #1;
    chk("rstmid_flush", {31'h0, bus.flush}, 32'h0);
    chk("rstmid_rv",    {31'h0, bus.redirect_valid}, 32'h0);
    chk("rstmid_sr",    bus.sr, 32'h0);
    chk("rstmid_cause", bus.cause, 32'h0);
    chk("rstmid_epc",   bus.epc, 32'h0);
    bus.hw_int = 0;
    idle_inputs();
    step();
    reset_n = 1;

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      reset_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) bus.hw_int = 6'($urandom);
      bus.m_valid    = ($urandom_range(0, 3) != 0);
      bus.m_pc       = {$urandom_range(0, 32'hFFFF), 2'b00};
      bus.m_bd       = $urandom_range(0, 1) == 1;
      bus.exc_valid  = ($urandom_range(0, 9) == 0);
      bus.exc_code   = 5'($urandom);
      bus.eret_valid = ($urandom_range(0, 7) == 0);
      bus.mtc0_valid = ($urandom_range(0, 2) == 0);
      bus.mtc0_addr  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
      bus.mtc0_data  = $urandom;
      bus.mfc0_addr  = 5'($urandom_range(10, 17));
      bus.pipe_ready = ($urandom_range(0, 2) != 0);
    end
    step();
    reset_n = 1;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
